grf_write_arbiter: RTL and testbench
====================================

// Module: grf_write_arbiter
// PURPOSE
//  Owns the single GRF write port. Shares it between the in-order WB stage
//  (priority requester) and a late-result port for long-latency producers
//  (MDU results, late loads), buffered in a small FIFO. Starvation of late
//  results is bounded by a forced one-cycle pipeline stall. Sits between
//  WB_TOP and GRF; also exports a pending-write mask for hazard control.
// PARAMETERS
//  DEPTH     4   late-result FIFO entries (power of 2, >=2)
//  MAX_WAIT  8   consecutive cycles a non-empty FIFO may lose the port (>=1)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  wb_addr        in   5   WB regWriteAddr; 0 = no write
//  wb_data        in   32  WB regWriteData
//  wb_pc          in   32  WB PC
//  lr_valid       in   1   late result offered
//  lr_ready       out  1   FIFO accepts late result (valid&ready = enqueue)
//  lr_addr        in   5   late result destination register
//  lr_data        in   32  late result data
//  lr_pc          in   32  PC of producing instruction
//  grf_we         out  1   GRF write enable
//  grf_addr       out  5   GRF write address
//  grf_data       out  32  GRF write data
//  grf_pc         out  32  PC of instruction being written (trace)
//  stall_pipe     out  1   freeze whole pipeline this cycle (registered)
//  pending_mask   out  32  bit r set while any FIFO entry targets reg r
// BEHAVIOUR
//  Reset: FIFO empty, state NORMAL, wait_cnt=0; lr_ready=1, grf_we=0,
//   grf_addr=0, grf_data=0, grf_pc=0, stall_pipe=0, pending_mask=0.
//  Enqueue: lr_valid&lr_ready at edge t -> entry written; earliest GRF write
//   in cycle t+1 (no bypass FIFO->port same cycle). lr_addr=0 accepted and
//   dropped (consumes no slot). lr_ready = (count<DEPTH), from registered
//   count only; a same-cycle dequeue does not raise ready when full.
//  Port select (combinational, one write per cycle):
//   NORMAL, wb_addr!=0 -> WB wins: we=1, addr/data/pc = wb_*.
//   NORMAL, wb_addr==0, FIFO non-empty -> pop head, write head fields.
//   FORCE -> pop head, write head; WB write suppressed (pipeline frozen by
//    stall_pipe, same WB instruction re-presented next cycle, written then).
//   nothing to write -> we=0, addr/data/pc hold last driven values.
//  FSM: NORMAL -> FORCE when FIFO non-empty, WB won port, wait_cnt==MAX_WAIT-1.
//   FORCE -> NORMAL always after 1 cycle. stall_pipe = (state==FORCE).
//  wait_cnt: +1 per cycle FIFO non-empty and WB wins; cleared on any pop,
//   when FIFO empty, and on entering FORCE. Saturates, never wraps.
//  FIFO: circular, rd/wr pointers log2(DEPTH) bits wrap naturally; count
//   log2(DEPTH)+1 bits. Simultaneous enqueue+pop: count unchanged.
//  pending_mask: OR of one-hot(addr) over valid entries, registered view
//   (updates the cycle after enqueue/pop). Bit 0 always 0.
//  Ordering: FIFO drains strictly in arrival order. WAW/RAW vs WB is not
//   resolved here; decode stalls on pending_mask.
//  Reset mid-operation: all buffered late results discarded, state NORMAL,
//   stall_pipe deasserts the same edge.
// TESTING
//  1 WB only: wb_addr=5,data=0x1234 each cycle, lr idle -> grf_we=1 same
//    cycle, addr 5, data 0x1234; stall_pipe never 1.
//  2 Idle port: enqueue lr_addr=9,data=0xBEEF at t, wb_addr=0 -> grf_we=1,
//    addr 9, data 0xBEEF at t+1; pending_mask[9]=1 during t+1, 0 at t+2.
//  3 Starvation: 1 entry queued, wb_addr!=0 continuously, MAX_WAIT=8 ->
//    stall_pipe=1 exactly once after 8 WB-won cycles, head written that
//    cycle, held WB instruction written the following cycle.
//  4 Full: enqueue 4 entries with WB busy -> lr_ready=0 after 4th; entries
//    drain in order 1..4 once wb_addr=0; lr_ready=1 after first pop.
//  5 $0 filtering: lr_addr=0 enqueue -> no slot used, no write; wb_addr=0
//    with empty FIFO -> grf_we=0.
//  6 Reset with 3 entries + FORCE active -> next cycle count 0, lr_ready=1,
//    stall_pipe=0, pending_mask=0, no late write ever issued.

Source files
------------

// File: rtl/grf_write_arbiter.sv
// ---------------------------------------------------------------------------
// GrfWriteArbiter (module grf_write_arbiter)
//
// Owns the single GRF write port and shares it between the in-order WB stage
// and a small FIFO of late results (MDU results, late loads). WB normally has
// priority; a late result that keeps losing the port is eventually forced
// through by freezing the whole pipeline for one cycle. A mask of registers
// with a write still sitting in the FIFO is exported for decode hazard checks.
//
// Parameters:
//   DEPTH     late-result FIFO entries (power of 2, >= 2)
//   MAX_WAIT  consecutive cycles a non-empty FIFO may lose the port (>= 1)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   wb_addr       WB destination register, 0 means no write
//   wb_data       WB write data
//   wb_pc         WB instruction PC
//   lr_valid      late result offered
//   lr_ready      FIFO can accept a late result
//   lr_addr       late result destination register (0 is accepted and dropped)
//   lr_data       late result data
//   lr_pc         PC of the instruction that produced the late result
//   grf_we        GRF write enable
//   grf_addr      GRF write address (holds last value when idle)
//   grf_data      GRF write data (holds last value when idle)
//   grf_pc        PC of the instruction being written (trace)
//   stall_pipe    freeze the pipeline this cycle (registered)
//   pending_mask  bit r set while any buffered late result targets register r
// ---------------------------------------------------------------------------
module grf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        lr_valid,
    output logic        lr_ready,
    input  logic [4:0]  lr_addr,
    input  logic [31:0] lr_data,
    input  logic [31:0] lr_pc,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    output logic [31:0] grf_pc,
    output logic        stall_pipe,
    output logic [31:0] pending_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t      state;

    logic [4:0]  fifo_addr [DEPTH];
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;

    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [31:0] last_pc;
    logic [31:0] pending_q;

    logic        fifo_nonempty;
    logic        enq;
    logic        pop;
    logic        wb_wins;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [31:0] sel_pc;
    logic [DEPTH-1:0] next_valid;
    logic [4:0]  next_entry_addr;
    logic [31:0] mask_next;

    assign fifo_nonempty = (count != '0);
    // Ready looks only at the registered count, so a pop in the same cycle
    // never lets a full FIFO accept.
    assign lr_ready      = (count < CW'(DEPTH));
    // A late result aimed at $0 is acknowledged but never stored.
    assign enq           = lr_valid && lr_ready && (lr_addr != 5'd0);

    // Port selection: WB wins in NORMAL, the FIFO head gets the port when WB
    // is idle or while the pipeline is frozen. Nothing is written while reset
    // is asserted so buffered results being discarded never reach the GRF.
    always_comb begin
        pop      = 1'b0;
        wb_wins  = 1'b0;
        sel_addr = last_addr;
        sel_data = last_data;
        sel_pc   = last_pc;
        if (!reset) begin
            if (state == FORCE) begin
                pop = fifo_nonempty;
            end else if (wb_addr != 5'd0) begin
                wb_wins = 1'b1;
            end else begin
                pop = fifo_nonempty;
            end
        end
        if (pop) begin
            sel_addr = fifo_addr[rd_ptr];
            sel_data = fifo_data[rd_ptr];
            sel_pc   = fifo_pc[rd_ptr];
        end else if (wb_wins) begin
            sel_addr = wb_addr;
            sel_data = wb_data;
            sel_pc   = wb_pc;
        end
    end

    assign grf_we       = pop || wb_wins;
    assign grf_addr     = sel_addr;
    assign grf_data     = sel_data;
    assign grf_pc       = sel_pc;
    assign stall_pipe   = (state == FORCE);
    assign pending_mask = pending_q;

    // Per-entry occupancy after this edge, and the pending mask it implies.
    // Registering this mask gives the "visible the cycle after" behaviour.
    always_comb begin
        next_valid      = fifo_valid;
        mask_next       = '0;
        next_entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_entry_addr = fifo_addr[i];
            if (pop && (PW'(i) == rd_ptr)) begin
                next_valid[i] = 1'b0;
            end
            if (enq && (PW'(i) == wr_ptr)) begin
                next_valid[i]   = 1'b1;
                next_entry_addr = lr_addr;
            end
            if (next_valid[i]) begin
                mask_next[next_entry_addr] = 1'b1;
            end
        end
        mask_next[0] = 1'b0;
    end

    // FIFO storage, pointers and count. Payload slots are not cleared on
    // reset; occupancy lives in fifo_valid and count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            fifo_valid <= '0;
            pending_q  <= '0;
        end else begin
            if (enq) begin
                fifo_addr[wr_ptr] <= lr_addr;
                fifo_data[wr_ptr] <= lr_data;
                fifo_pc[wr_ptr]   <= lr_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !enq) begin
                count <= count - CW'(1);
            end
            fifo_valid <= next_valid;
            pending_q  <= mask_next;
        end
    end

    // Remember the last driven address/data/pc so the port holds them on
    // idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= '0;
            last_data <= '0;
            last_pc   <= '0;
        end else if (grf_we) begin
            last_addr <= sel_addr;
            last_data <= sel_data;
            last_pc   <= sel_pc;
        end
    end

    // Starvation guard: count consecutive cycles the FIFO loses to WB and,
    // on the MAX_WAIT-th loss, spend one frozen cycle draining the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORMAL;
            wait_cnt <= '0;
        end else begin
            case (state)
                NORMAL: begin
                    if (wb_wins && fifo_nonempty && (wait_cnt == WW'(MAX_WAIT - 1))) begin
                        state    <= FORCE;
                        wait_cnt <= '0;
                    end else if (pop || !fifo_nonempty) begin
                        wait_cnt <= '0;
                    end else if (wb_wins && (wait_cnt != '1)) begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                FORCE: begin
                    state    <= NORMAL;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= NORMAL;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// ---------------------------------------------------------------------------
// TbGrfWriteArbiter (module tb_grf_write_arbiter)
//
// Drives directed scenarios followed by random traffic into the write
// arbiter. A queue-based reference model predicts each cycle's port outputs;
// predictions go into a scoreboard queue and a negedge monitor pops and
// compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_grf_write_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk;
    logic        reset;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        lr_valid;
    logic        lr_ready;
    logic [4:0]  lr_addr;
    logic [31:0] lr_data;
    logic [31:0] lr_pc;
    logic        grf_we;
    logic [4:0]  grf_addr;
    logic [31:0] grf_data;
    logic [31:0] grf_pc;
    logic        stall_pipe;
    logic [31:0] pending_mask;

    grf_write_arbiter #(
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .lr_valid     (lr_valid),
        .lr_ready     (lr_ready),
        .lr_addr      (lr_addr),
        .lr_data      (lr_data),
        .lr_pc        (lr_pc),
        .grf_we       (grf_we),
        .grf_addr     (grf_addr),
        .grf_data     (grf_data),
        .grf_pc       (grf_pc),
        .stall_pipe   (stall_pipe),
        .pending_mask (pending_mask)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } lr_t;

    typedef struct {
        bit          chkAll;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic        stall;
        logic        ready;
        logic [31:0] mask;
    } exp_t;

    // Reference model state: buffered late results in arrival order, how
    // long the queue has been losing, whether a frozen cycle is due, and
    // what the port last drove.
    lr_t         modelQ[$];
    int          modelWait;
    bit          modelForce;
    logic [4:0]  lastAddr;
    logic [31:0] lastData;
    logic [31:0] lastPc;

    logic [4:0]  prevWbAddr;
    logic [31:0] prevWbData;
    logic [31:0] prevWbPc;

    exp_t        expQ[$];
    int          vectors;
    int          miscompares;

    // One field comparison; every call counts as a vector.
    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        compareField("grf_we", {31'd0, grf_we}, {31'd0, e.we});
        if (e.chkAll) begin
            compareField("grf_addr", {27'd0, grf_addr}, {27'd0, e.addr});
            compareField("grf_data", grf_data, e.data);
            compareField("grf_pc", grf_pc, e.pc);
            compareField("stall_pipe", {31'd0, stall_pipe}, {31'd0, e.stall});
            compareField("lr_ready", {31'd0, lr_ready}, {31'd0, e.ready});
            compareField("pending_mask", pending_mask, e.mask);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs for that cycle and
    // advance the reference model past the coming clock edge. While the
    // pipeline is frozen the previous WB instruction is re-presented.
    task automatic applyStimulus(input bit rst, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [31:0] wp, input bit lv, input logic [4:0] la,
                                 input logic [31:0] ld, input logic [31:0] lp);
        exp_t e;
        lr_t  h;
        lr_t  n;
        bit   rdy;
        bit   had;
        @(posedge clk);
        #1;
        if (modelForce && !rst) begin
            wa = prevWbAddr;
            wd = prevWbData;
            wp = prevWbPc;
        end
        reset    = rst;
        wb_addr  = wa;
        wb_data  = wd;
        wb_pc    = wp;
        lr_valid = lv;
        lr_addr  = la;
        lr_data  = ld;
        lr_pc    = lp;
        prevWbAddr = wa;
        prevWbData = wd;
        prevWbPc   = wp;

        e.chkAll = 1'b0;
        e.we     = 1'b0;
        e.addr   = '0;
        e.data   = '0;
        e.pc     = '0;
        e.stall  = 1'b0;
        e.ready  = 1'b1;
        e.mask   = '0;

        if (rst) begin
            modelQ.delete();
            modelWait  = 0;
            modelForce = 1'b0;
            lastAddr   = '0;
            lastData   = '0;
            lastPc     = '0;
        end else begin
            e.chkAll = 1'b1;
            rdy      = (modelQ.size() < DEPTH);
            e.ready  = rdy;
            e.stall  = modelForce;
            foreach (modelQ[i]) e.mask[modelQ[i].addr] = 1'b1;
            e.mask[0] = 1'b0;
            had = (modelQ.size() > 0);

            if (modelForce && had) begin
                h = modelQ.pop_front();
                e.we = 1'b1;
                lastAddr = h.addr; lastData = h.data; lastPc = h.pc;
                modelForce = 1'b0;
                modelWait  = 0;
            end else if (wa != 5'd0) begin
                e.we = 1'b1;
                lastAddr = wa; lastData = wd; lastPc = wp;
                if (had) begin
                    if (modelWait == MAX_WAIT - 1) begin
                        modelForce = 1'b1;
                        modelWait  = 0;
                    end else begin
                        modelWait++;
                    end
                end
            end else if (had) begin
                h = modelQ.pop_front();
                e.we = 1'b1;
                lastAddr = h.addr; lastData = h.data; lastPc = h.pc;
                modelWait = 0;
            end
            if (!had) modelWait = 0;

            e.addr = lastAddr;
            e.data = lastData;
            e.pc   = lastPc;

            if (lv && rdy && (la != 5'd0)) begin
                n.addr = la; n.data = ld; n.pc = lp;
                modelQ.push_back(n);
            end
        end
        expQ.push_back(e);
    endtask

    // Monitor: outputs are settled by the falling edge, compare there.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        modelWait   = 0;
        modelForce  = 1'b0;
        lastAddr    = '0;
        lastData    = '0;
        lastPc      = '0;
        prevWbAddr  = '0;
        prevWbData  = '0;
        prevWbPc    = '0;
        reset       = 1'b1;
        wb_addr     = '0;
        wb_data     = '0;
        wb_pc       = '0;
        lr_valid    = 1'b0;
        lr_addr     = '0;
        lr_data     = '0;
        lr_pc       = '0;

        // Reset, then one idle cycle checking every reset value.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // WB only: written the same cycle, never stalls.
        for (int i = 0; i < 5; i++) applyStimulus(0, 5, 32'h1234, 32'h100 + 32'(i * 4), 0, 0, 0, 0);

        // Idle port: late result written the cycle after enqueue.
        applyStimulus(0, 0, 0, 0, 1, 9, 32'hBEEF, 32'h2000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: one entry against a continuously busy WB.
        applyStimulus(0, 7, 32'h7000, 32'h300, 1, 12, 32'hCAFE, 32'h3000);
        for (int i = 0; i < 12; i++) applyStimulus(0, 7, 32'h7001 + 32'(i), 32'h304 + 32'(i * 4), 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Full: four entries with WB busy, a fifth offer refused, then drain.
        for (int i = 1; i <= 5; i++)
            applyStimulus(0, 3, 32'h3300 + 32'(i), 32'h400 + 32'(i * 4), 1, 5'(i + (i / 5)),
                          32'hA000 + 32'(i), 32'h4000 + 32'(i));
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // $0 filtering: no slot, no write.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hDEAD, 32'h5000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while three entries are buffered and a frozen cycle is active.
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 4, 32'h4400 + 32'(i), 32'h500, 1, 5'(20 + i), 32'hB000 + 32'(i), 32'h6000);
        for (int i = 0; i < 20 && !modelForce; i++) applyStimulus(0, 4, 32'h4500 + 32'(i), 32'h504, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bit          rst;
            logic [4:0]  wa;
            logic [4:0]  la;
            rst = ($urandom_range(0, 399) == 0);
            wa  = ($urandom_range(0, 9) < 4 || rst) ? 5'd0 : 5'($urandom);
            la  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            applyStimulus(rst, wa, $urandom, $urandom, 1'($urandom), la, $urandom, $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Let the monitor consume the last prediction.
        repeat (2) @(posedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
